// File: rtl/pll_rst_pkg.sv
// Shared definitions for the video PLL reset/lock sequencer: FSM state
// encodings and the default cycle counts for a 50 MHz reference clock.
package pll_rst_pkg;

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABLE     = 3'd2,
    RUN        = 3'd3,
    FAIL       = 3'd4
  } state_t;

  localparam int DEF_RST_HOLD_CYCLES     = 1000;    // 20 us
  localparam int DEF_LOCK_STABLE_CYCLES  = 5000;    // 100 us
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 500000;  // 10 ms
  localparam int DEF_MAX_RETRIES         = 7;
  localparam int DEF_CNT_W               = 20;

endpackage

// File: rtl/pll_rst_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous status bit; both flops
// clear to 0 on reset so a stale "good" status is never reported.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_rst_ctrl.sv
// PLL reset and lock sequencer: pulses pll_rst, qualifies lock over a stable
// window before releasing sys_rst, re-resets on lock loss, fails after retries.
module pll_rst_ctrl
  import pll_rst_pkg::*;
#(
  parameter int RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int CNT_W               = DEF_CNT_W
) (
  input  logic       clkin1,
  input  logic       rst,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       lock_sync,
  output logic [7:0] relock_cnt,
  output logic       fail,
  output logic [2:0] state
);

  localparam logic [CNT_W-1:0] HOLD_END    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_END  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_END = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       RETRY_LIMIT = 8'(MAX_RETRIES);

  state_t           state_q, state_next;
  logic [CNT_W-1:0] cnt_q, cnt_next;
  logic [7:0]       retry_q, retry_next, relock_next;

  sync_2ff u_lock_sync (
    .clk (clkin1),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_sync)
  );

  always_ff @(posedge clkin1 or posedge rst) begin
    if (rst) begin
      state_q    <= RESET_HOLD;
      cnt_q      <= '0;
      retry_q    <= '0;
      relock_cnt <= '0;
      pll_rst    <= 1'b1;
      sys_rst    <= 1'b1;
      fail       <= 1'b0;
    end else begin
      state_q    <= state_next;
      cnt_q      <= cnt_next;
      retry_q    <= retry_next;
      relock_cnt <= relock_next;
      // Outputs decode the next state so they change on the same edge as it.
      pll_rst    <= (state_next == RESET_HOLD);
      sys_rst    <= (state_next != RUN);
      fail       <= (state_next == FAIL);
    end
  end

  always_comb begin
    state_next  = state_q;
    cnt_next    = cnt_q + CNT_W'(1);
    retry_next  = retry_q;
    relock_next = relock_cnt;
    case (state_q)
      RESET_HOLD: begin
        if (cnt_q == HOLD_END) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end
      end
      WAIT_LOCK: begin
        // Lock has priority over a timeout landing on the same cycle.
        if (lock_sync) begin
          state_next = STABLE;
          cnt_next   = '0;
        end else if (cnt_q == TIMEOUT_END) begin
          cnt_next   = '0;
          retry_next = retry_q + 8'd1;
          state_next = (retry_next == RETRY_LIMIT) ? FAIL : RESET_HOLD;
        end
      end
      STABLE: begin
        if (!lock_sync) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_q == STABLE_END) begin
          state_next = RUN;
          cnt_next   = '0;
          retry_next = '0;
        end
      end
      RUN: begin
        cnt_next = '0;
        if (!lock_sync) begin
          state_next  = RESET_HOLD;
          relock_next = (relock_cnt == 8'hFF) ? relock_cnt : relock_cnt + 8'd1;
        end
      end
      FAIL: begin
        cnt_next = '0;
      end
      default: begin
        state_next = RESET_HOLD;
        cnt_next   = '0;
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Bench for pll_rst_ctrl: expected output transitions (snapshot plus cycles
// since the previous transition) are queued by stimulus and checked by a monitor.
module tb_pll_rst_ctrl;

  localparam int W = 30;  // {gap[15:0], state[2:0], pll_rst, sys_rst, fail, relock[7:0]}

  logic       clk;
  logic       rst;
  logic       pll_lock;
  logic       pll_rst;
  logic       sys_rst;
  logic       lock_sync;
  logic [7:0] relock_cnt;
  logic       fail;
  logic [2:0] state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  pll_rst_ctrl #(
    .RST_HOLD_CYCLES     (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .MAX_RETRIES         (2),
    .CNT_W               (20)
  ) dut (
    .clkin1     (clk),
    .rst        (rst),
    .pll_lock   (pll_lock),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .lock_sync  (lock_sync),
    .relock_cnt (relock_cnt),
    .fail       (fail),
    .state      (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  function automatic void push(input int gap, input logic [2:0] st, input logic pr,
                               input logic sr, input logic f, input logic [7:0] rc);
    exp_q.push_back({16'(gap), st, pr, sr, f, rc});
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d expected transitions still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic apply_reset(input logic lock_val);
    wait_drain();
    @(negedge clk);
    #1 rst = 1'b1;
    pll_lock = lock_val;
    #1;  // still well before the next rising edge
    chk("rst_pll_rst", 16'(pll_rst), 16'd1);
    chk("rst_sys_rst", 16'(sys_rst), 16'd1);
    chk("rst_fail", 16'(fail), 16'd0);
    chk("rst_relock_cnt", 16'(relock_cnt), 16'd0);
    chk("rst_lock_sync", 16'(lock_sync), 16'd0);
    chk("rst_state", 16'(state), 16'd0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- monitor ----------------
  logic [13:0] last_snap;
  int          gap;

  always @(negedge clk) begin
    logic [13:0]  cur;
    logic [W-1:0] e;
    cur = {state, pll_rst, sys_rst, fail, relock_cnt};
    if (rst) begin
      last_snap = cur;
      gap = 0;
    end else begin
      gap++;
      if (cur != last_snap) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got gap=%0d state=%0d pll_rst=%b sys_rst=%b fail=%b relock=%0d, expected no change",
                   gap, cur[13:11], cur[10], cur[9], cur[8], cur[7:0]);
        end else begin
          e = exp_q.pop_front();
          if (e != {16'(gap), cur}) begin
            errors++;
            $display("FAIL transition: got gap=%0d state=%0d pll_rst=%b sys_rst=%b fail=%b relock=%0d, expected gap=%0d state=%0d pll_rst=%b sys_rst=%b fail=%b relock=%0d",
                     gap, cur[13:11], cur[10], cur[9], cur[8], cur[7:0],
                     e[29:14], e[13:11], e[10], e[9], e[8], e[7:0]);
          end
        end
        last_snap = cur;
        gap = 0;
      end
    end
  end

  // ---------------- driver / directed scenarios ----------------
  initial begin
    rst = 1'b1;
    pll_lock = 1'b0;

    // 1: lock rises 10 cycles after pll_rst falls; 2+8+1 edges to sys_rst release
    apply_reset(1'b0);
    push(4, 3'd1, 1'b0, 1'b1, 1'b0, 8'd0);
    push(13, 3'd2, 1'b0, 1'b1, 1'b0, 8'd0);
    push(8, 3'd3, 1'b0, 1'b0, 1'b0, 8'd0);
    step(14);
    pll_lock = 1'b1;
    step(1);
    chk("lock_sync_lag1", 16'(lock_sync), 16'd0);
    step(1);
    chk("lock_sync_lag2", 16'(lock_sync), 16'd1);
    wait_drain();

    // 2: one-cycle lock glitch in STABLE restarts qualification, no retry
    apply_reset(1'b0);
    push(4, 3'd1, 1'b0, 1'b1, 1'b0, 8'd0);
    push(3, 3'd2, 1'b0, 1'b1, 1'b0, 8'd0);
    push(6, 3'd1, 1'b0, 1'b1, 1'b0, 8'd0);
    push(1, 3'd2, 1'b0, 1'b1, 1'b0, 8'd0);
    push(8, 3'd3, 1'b0, 1'b0, 1'b0, 8'd0);
    step(4);
    pll_lock = 1'b1;
    step(6);
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;

    // 3: lock loss in RUN -> re-reset 3 edges later, relock_cnt=1, relock
    step(11);
    push(3, 3'd0, 1'b1, 1'b1, 1'b0, 8'd1);
    push(4, 3'd1, 1'b0, 1'b1, 1'b0, 8'd1);
    push(1, 3'd2, 1'b0, 1'b1, 1'b0, 8'd1);
    push(8, 3'd3, 1'b0, 1'b0, 1'b0, 8'd1);
    pll_lock = 1'b0;
    step(3);
    pll_lock = 1'b1;
    wait_drain();
    chk("relock_after_loss", 16'(relock_cnt), 16'd1);

    // 4: no lock ever -> two timeouts, then sticky FAIL ignoring lock
    apply_reset(1'b0);
    push(4, 3'd1, 1'b0, 1'b1, 1'b0, 8'd0);
    push(32, 3'd0, 1'b1, 1'b1, 1'b0, 8'd0);
    push(4, 3'd1, 1'b0, 1'b1, 1'b0, 8'd0);
    push(32, 3'd4, 1'b0, 1'b1, 1'b1, 8'd0);
    wait_drain();
    pll_lock = 1'b1;
    step(20);
    chk("fail_state", 16'(state), 16'd4);
    chk("fail_flag", 16'(fail), 16'd1);
    chk("fail_pll_rst", 16'(pll_rst), 16'd0);
    chk("fail_sys_rst", 16'(sys_rst), 16'd1);

    // 5: 260 lock losses in RUN -> relock_cnt saturates at 255
    apply_reset(1'b1);
    push(4, 3'd1, 1'b0, 1'b1, 1'b0, 8'd0);
    push(1, 3'd2, 1'b0, 1'b1, 1'b0, 8'd0);
    push(8, 3'd3, 1'b0, 1'b0, 1'b0, 8'd0);
    step(13);
    for (int i = 0; i < 260; i++) begin
      logic [7:0] rc;
      rc = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
      push(3, 3'd0, 1'b1, 1'b1, 1'b0, rc);
      push(4, 3'd1, 1'b0, 1'b1, 1'b0, rc);
      push(1, 3'd2, 1'b0, 1'b1, 1'b0, rc);
      push(8, 3'd3, 1'b0, 1'b0, 1'b0, rc);
      pll_lock = 1'b0;
      step(3);
      pll_lock = 1'b1;
      step(13);
    end
    wait_drain();
    chk("relock_saturated", 16'(relock_cnt), 16'd255);

    // 6: rst mid-STABLE and mid-RUN forces reset values asynchronously
    apply_reset(1'b1);
    push(4, 3'd1, 1'b0, 1'b1, 1'b0, 8'd0);
    push(1, 3'd2, 1'b0, 1'b1, 1'b0, 8'd0);
    step(7);
    apply_reset(1'b1);
    push(4, 3'd1, 1'b0, 1'b1, 1'b0, 8'd0);
    push(1, 3'd2, 1'b0, 1'b1, 1'b0, 8'd0);
    push(8, 3'd3, 1'b0, 1'b0, 1'b0, 8'd0);
    step(13);
    push(3, 3'd0, 1'b1, 1'b1, 1'b0, 8'd1);
    push(4, 3'd1, 1'b0, 1'b1, 1'b0, 8'd1);
    push(1, 3'd2, 1'b0, 1'b1, 1'b0, 8'd1);
    push(8, 3'd3, 1'b0, 1'b0, 1'b0, 8'd1);
    pll_lock = 1'b0;
    step(3);
    pll_lock = 1'b1;
    step(13);
    apply_reset(1'b1);
    push(4, 3'd1, 1'b0, 1'b1, 1'b0, 8'd0);
    push(1, 3'd2, 1'b0, 1'b1, 1'b0, 8'd0);
    push(8, 3'd3, 1'b0, 1'b0, 1'b0, 8'd0);
    step(13);
    wait_drain();
    chk("relock_after_rst", 16'(relock_cnt), 16'd0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
